// File: rtl/signed_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : signed_add_mult
//  Purpose  : Two independent signed arithmetic units sharing one clock.
//             - add/sub unit : single-cycle registered add or subtract
//             - multiply unit: 16-step shift-add multiplier (IDLE/RUN/DONE)
//             Both results wrap modulo 2^WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module signed_add_mult #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    // add/sub unit
    input  logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH-1:0] add_in2,
    input  logic             sub,
    input  logic             start_add,
    output logic [WIDTH-1:0] add_out,
    output logic             add_finish,
    // multiply unit
    input  logic [WIDTH-1:0] mult_in1,
    input  logic [WIDTH-1:0] mult_in2,
    input  logic             start_mult,
    output logic [WIDTH-1:0] mult_out,
    output logic             mult_finish
);

    // Step counter wide enough to index every multiplier bit.
    localparam int               c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;   // multiplier, shifted right each step
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_count;

    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_add_res;
    logic [WIDTH-1:0]   w_partial;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last_step;

    // Subtraction is add_in1 + ~add_in2 + 1; the carry-in is the sub bit.
    assign w_add_b   = sub ? ~add_in2 : add_in2;
    assign w_add_res = add_in1 + w_add_b + {{(WIDTH-1){1'b0}}, sub};

    // Low WIDTH bits of the unsigned product equal those of the signed one,
    // so a plain unsigned shift-add is sufficient.
    assign w_partial   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next  = r_acc + w_partial;
    assign w_last_step = (r_count == c_LAST);

    assign mult_finish = (r_state == DONE);

    // Add/sub result and one-cycle completion flag for every sampled request.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            add_out    <= '0;
            add_finish <= 1'b0;
        end else begin
            add_finish <= start_add;
            if (start_add) begin
                add_out <= w_add_res;
            end
        end
    end

    // Multiply FSM state register.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Multiply FSM next-state: requests outside IDLE are dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_mult)  w_next_state = RUN;
            RUN:     if (w_last_step) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Multiply datapath: operand capture, shift-add steps, result commit.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            mult_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_mult) begin
                        r_mcand  <= mult_in1;
                        r_mplier <= mult_in2;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + c_ONE;
                    if (w_last_step) begin
                        mult_out <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signed_add_mult
//  Purpose  : Directed self-checking bench for signed_add_mult.
//  Revision : 1.0  initial release
// ============================================================================
module tb_signed_add_mult;

    logic        clk = 1'b0;
    logic        nRST;
    logic [15:0] add_in1, add_in2;
    logic        sub, start_add;
    logic [15:0] add_out;
    logic        add_finish;
    logic [15:0] mult_in1, mult_in2;
    logic        start_mult;
    logic [15:0] mult_out;
    logic        mult_finish;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_mult;

    always #5 clk = ~clk;

    signed_add_mult #(.WIDTH(16)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .sub        (sub),
        .start_add  (start_add),
        .add_out    (add_out),
        .add_finish (add_finish),
        .mult_in1   (mult_in1),
        .mult_in2   (mult_in2),
        .start_mult (start_mult),
        .mult_out   (mult_out),
        .mult_finish(mult_finish)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; start_add = 1'b1; start_mult = 1'b1;
        add_in1 = 16'd3; add_in2 = 16'd4; sub = 1'b0;
        mult_in1 = 16'd3; mult_in2 = 16'd3;
        repeat (3) step();
        n_checks++; if (add_out !== 16'h0000) begin n_fail++; $display("FAIL reset_add_out: got %h expected %h", add_out, 16'h0000); end
        n_checks++; if (mult_out !== 16'h0000) begin n_fail++; $display("FAIL reset_mult_out: got %h expected %h", mult_out, 16'h0000); end
        n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL reset_add_finish: got %b expected 0", add_finish); end
        n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL reset_mult_finish: got %b expected 0", mult_finish); end
        start_add = 1'b0; start_mult = 1'b0; nRST = 1'b1;
        step();
        n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL reset_release_add_finish: got %b expected 0", add_finish); end
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL reset_no_queued_mult cycle %0d: got %b expected 0", c, mult_finish); end
            step();
        end
        exp_mult = 16'h0000;
    endtask

    task automatic test_add();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vs [3];
        logic [15:0] ve [3];
        va[0] = 16'd25;   vb[0] = 16'd17; vs[0] = 1'b0; ve[0] = 16'd42;
        va[1] = 16'd5;    vb[1] = 16'd9;  vs[1] = 1'b1; ve[1] = 16'hFFFC;
        va[2] = 16'h7FFF; vb[2] = 16'd1;  vs[2] = 1'b0; ve[2] = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            add_in1 = va[i]; add_in2 = vb[i]; sub = vs[i]; start_add = 1'b1;
            step();
            start_add = 1'b0;
            n_checks++; if (add_finish !== 1'b1) begin n_fail++; $display("FAIL add_finish_pulse[%0d]: got %b expected 1", i, add_finish); end
            n_checks++; if (add_out !== ve[i]) begin n_fail++; $display("FAIL add_result[%0d]: got %h expected %h", i, add_out, ve[i]); end
            add_in1 = 16'h1234; add_in2 = 16'h4321;
            step();
            n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL add_finish_drop[%0d]: got %b expected 0", i, add_finish); end
            n_checks++; if (add_out !== ve[i]) begin n_fail++; $display("FAIL add_hold[%0d]: got %h expected %h", i, add_out, ve[i]); end
        end
        n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL add_no_mult_finish: got %b expected 0", mult_finish); end
        n_checks++; if (mult_out !== exp_mult) begin n_fail++; $display("FAIL add_mult_out_untouched: got %h expected %h", mult_out, exp_mult); end
    endtask

    task automatic test_back_to_back();
        add_in1 = 16'd100; add_in2 = 16'hFFFF; sub = 1'b0; start_add = 1'b1;
        step();
        n_checks++; if (add_finish !== 1'b1) begin n_fail++; $display("FAIL b2b_finish_0: got %b expected 1", add_finish); end
        n_checks++; if (add_out !== 16'd99) begin n_fail++; $display("FAIL b2b_result_0: got %h expected %h", add_out, 16'd99); end
        add_in1 = 16'h8000; add_in2 = 16'd1; sub = 1'b1;
        step();
        start_add = 1'b0;
        n_checks++; if (add_finish !== 1'b1) begin n_fail++; $display("FAIL b2b_finish_1: got %b expected 1", add_finish); end
        n_checks++; if (add_out !== 16'h7FFF) begin n_fail++; $display("FAIL b2b_result_1: got %h expected %h", add_out, 16'h7FFF); end
        step();
        n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL b2b_finish_end: got %b expected 0", add_finish); end
        n_checks++; if (add_out !== 16'h7FFF) begin n_fail++; $display("FAIL b2b_hold: got %h expected %h", add_out, 16'h7FFF); end
    endtask

    task automatic test_mult(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] e, input string name);
        mult_in1 = a; mult_in2 = b; start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        mult_in1 = 16'hDEAD; mult_in2 = 16'hBEEF;
        for (int c = 1; c <= 16; c++) begin
            n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL %s_early_finish cycle %0d: got %b expected 0", name, c, mult_finish); end
            n_checks++; if (mult_out !== exp_mult) begin n_fail++; $display("FAIL %s_out_during_run cycle %0d: got %h expected %h", name, c, mult_out, exp_mult); end
            step();
        end
        exp_mult = e;
        n_checks++; if (mult_finish !== 1'b1) begin n_fail++; $display("FAIL %s_finish_cycle17: got %b expected 1", name, mult_finish); end
        n_checks++; if (mult_out !== e) begin n_fail++; $display("FAIL %s_result: got %h expected %h", name, mult_out, e); end
        step();
        n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL %s_finish_drop: got %b expected 0", name, mult_finish); end
        n_checks++; if (mult_out !== e) begin n_fail++; $display("FAIL %s_hold: got %h expected %h", name, mult_out, e); end
    endtask

    task automatic test_concurrent();
        mult_in1 = 16'd100; mult_in2 = 16'd3; start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) begin
                add_in1 = 16'd1; add_in2 = 16'd2; sub = 1'b0; start_add = 1'b1;
            end
            if (c == 3) begin
                start_add = 1'b0;
                n_checks++; if (add_finish !== 1'b1) begin n_fail++; $display("FAIL conc_add_finish: got %b expected 1", add_finish); end
                n_checks++; if (add_out !== 16'd3) begin n_fail++; $display("FAIL conc_add_result: got %h expected %h", add_out, 16'd3); end
            end
            if (c == 4) begin
                n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL conc_add_finish_drop: got %b expected 0", add_finish); end
            end
            if (c == 5) begin
                mult_in1 = 16'd9; mult_in2 = 16'd9; start_mult = 1'b1;
            end
            if (c == 6) start_mult = 1'b0;
            n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL conc_early_finish cycle %0d: got %b expected 0", c, mult_finish); end
            n_checks++; if (mult_out !== exp_mult) begin n_fail++; $display("FAIL conc_out_during_run cycle %0d: got %h expected %h", c, mult_out, exp_mult); end
            step();
        end
        exp_mult = 16'd300;
        n_checks++; if (mult_finish !== 1'b1) begin n_fail++; $display("FAIL conc_mult_finish: got %b expected 1", mult_finish); end
        n_checks++; if (mult_out !== 16'd300) begin n_fail++; $display("FAIL conc_mult_result: got %h expected %h", mult_out, 16'd300); end
        // A request presented while in DONE must also be dropped.
        mult_in1 = 16'd9; mult_in2 = 16'd9; start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL conc_ignored_mult cycle %0d: got %b expected 0", c, mult_finish); end
            n_checks++; if (mult_out !== 16'd300) begin n_fail++; $display("FAIL conc_mult_hold cycle %0d: got %h expected %h", c, mult_out, 16'd300); end
            step();
        end
        n_checks++; if (add_out !== 16'd3) begin n_fail++; $display("FAIL conc_add_hold: got %h expected %h", add_out, 16'd3); end
    endtask

    task automatic test_reset_abort();
        mult_in1 = 16'd11; mult_in2 = 16'd13; start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        repeat (7) step();
        n_checks++; if (mult_out !== exp_mult) begin n_fail++; $display("FAIL abort_pre_reset_out: got %h expected %h", mult_out, exp_mult); end
        nRST = 1'b0; start_mult = 1'b1; mult_in1 = 16'd7; mult_in2 = 16'd7;
        start_add = 1'b1; add_in1 = 16'd50; add_in2 = 16'd50; sub = 1'b0;
        step();
        n_checks++; if (mult_out !== 16'h0000) begin n_fail++; $display("FAIL abort_mult_out: got %h expected %h", mult_out, 16'h0000); end
        n_checks++; if (add_out !== 16'h0000) begin n_fail++; $display("FAIL abort_add_out: got %h expected %h", add_out, 16'h0000); end
        n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL abort_mult_finish: got %b expected 0", mult_finish); end
        n_checks++; if (add_finish !== 1'b0) begin n_fail++; $display("FAIL abort_add_finish: got %b expected 0", add_finish); end
        step();
        start_mult = 1'b0; start_add = 1'b0; nRST = 1'b1;
        exp_mult = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++; if (mult_finish !== 1'b0) begin n_fail++; $display("FAIL abort_no_finish cycle %0d: got %b expected 0", c, mult_finish); end
        end
        n_checks++; if (mult_out !== 16'h0000) begin n_fail++; $display("FAIL abort_out_zero: got %h expected %h", mult_out, 16'h0000); end
        test_mult(16'd4, 16'd5, 16'd20, "post_reset_4x5");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        nRST = 1'b0; start_add = 1'b0; start_mult = 1'b0; sub = 1'b0;
        add_in1 = '0; add_in2 = '0; mult_in1 = '0; mult_in2 = '0;
        exp_mult = '0;
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_mult(16'd123,  16'd45,   16'd5535,  "m123x45");
        test_mult(16'hFFF9, 16'd6,    16'hFFD6,  "m_neg7x6");
        test_mult(16'd300,  16'd300,  16'd24464, "m300x300");
        test_mult(16'hFFFD, 16'hFFFB, 16'd15,    "m_neg3x_neg5");
        test_mult(16'h8000, 16'd2,    16'h0000,  "m_min_x2");
        test_concurrent();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signed_add_mult.md
SIGNED_ADD_MULT -- requirements
Module: signed_add_mult

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; all width figures below assume WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 nRST  input  1  reset; synchronous, active-low.
REQ-004 add_in1  input  16  signed two's-complement first operand of the add/sub unit.
REQ-005 add_in2  input  16  signed two's-complement second operand of the add/sub unit.
REQ-006 sub  input  1  operation select: 0 = add_in1+add_in2, 1 = add_in1-add_in2.
REQ-007 start_add  input  1  add/sub request, sampled on a rising edge.
REQ-008 add_out  output  16  signed add/sub result.
REQ-009 add_finish  output  1  add/sub completion pulse.
REQ-010 mult_in1  input  16  signed two's-complement multiplicand.
REQ-011 mult_in2  input  16  signed two's-complement multiplier.
REQ-012 start_mult  input  1  multiply request, sampled on a rising edge.
REQ-013 mult_out  output  16  signed product, low 16 bits.
REQ-014 mult_finish  output  1  multiply completion pulse.

Function
REQ-015 The add/sub unit and the multiply unit SHALL operate independently and concurrently; a request to one SHALL NOT affect the other.
REQ-016 Add/sub unit:
- On the edge where start_add=1, capture add_in1, add_in2 and sub.
- Register the result into add_out on that same edge.
- Drive add_finish=1 for exactly the following cycle (latency 1).
REQ-017 Add/sub arithmetic:
- Compute modulo 2^16, wrapping on overflow.
- Subtraction = add_in1 + ~add_in2 + 1.
- No overflow flag.
REQ-018 If start_add is held high, the add/sub unit SHALL recompute on every edge, and add_finish SHALL stay high one cycle after each sampled request.
REQ-019 Multiply unit FSM states: IDLE, RUN, DONE.
REQ-020 Multiply transitions:
- IDLE -> RUN when start_mult=1: capture both operands, clear the accumulator, load counter = 0.
- RUN: perform one shift-add step per cycle for 16 cycles over the bits of mult_in2 (LSB first), accumulating mod 2^16.
- RUN -> DONE after the 16th step, with the result written to mult_out.
- DONE -> IDLE unconditionally after one cycle.
REQ-021 mult_finish SHALL be 1 only while the multiply FSM is in DONE (a one-cycle pulse) and SHALL rise exactly 17 cycles after the start_mult sampling edge.
REQ-022 The multiply result SHALL equal the low 16 bits of the mathematical signed product, which equals the low 16 bits of the unsigned product.
REQ-023 start_mult asserted while the FSM is in RUN or DONE SHALL be ignored; no queuing of requests.
REQ-024 add_out and mult_out SHALL hold their last result until the next completion of their own unit, and SHALL NOT change during RUN.
REQ-025 The multiply accumulator SHALL be internal; mult_out SHALL update only on the transition into DONE.

Reset
REQ-026 While nRST=0 at a rising edge, the block SHALL:
- clear add_out, mult_out, add_finish and mult_finish to 0;
- return the multiply FSM to IDLE and clear its counter and accumulator;
- ignore both start inputs.
REQ-027 A reset asserted mid-multiply SHALL abort the operation with no mult_finish pulse; the first start_mult sampled after nRST returns to 1 SHALL begin a fresh operation.

Verification
REQ-028 start_add pulse with 25, 17, sub=0 -> next cycle add_finish=1 for one cycle, add_out=42.
REQ-029 start_add with 5, 9, sub=1 -> add_out=-4 (0xFFFC); and 32767+1, sub=0 -> add_out=-32768 (0x8000).
REQ-030 start_mult with 123, 45 -> mult_finish high exactly in cycle 17 after start for one cycle, mult_out=5535; mult_out unchanged during cycles 1-16.
REQ-031 start_mult with -7, 6 -> mult_out=-42 (0xFFD6); with 300, 300 -> mult_out=24464 (90000 mod 65536).
REQ-032 start_mult 100, 3, then start_add 1, 2 two cycles later and start_mult 9, 9 during RUN -> add_out=3 with its own finish pulse, single mult_finish with mult_out=300, second multiply ignored.
REQ-033 nRST=0 at cycle 8 of a multiply -> outputs 0, no mult_finish; after release, start_mult 4, 5 -> mult_out=20 after 17 cycles.
